// File: rtl/frame_buf_pkg.sv
// Shared types and defaults for the ping-pong frame buffer.
package frame_buf_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

  localparam int DEF_DEPTH  = 10000;
  localparam int DEF_CH_W   = 8;
  localparam int DEF_NCH    = 3;
  localparam int DEF_ADDR_W = 20;
  localparam int DEF_PIX_W  = DEF_NCH * DEF_CH_W;

  // Channel 0 (R) sits in the LSBs, then G, then B.
  function automatic logic [DEF_PIX_W-1:0] pix_pack(input logic [DEF_CH_W-1:0] r,
                                                    input logic [DEF_CH_W-1:0] g,
                                                    input logic [DEF_CH_W-1:0] b);
    return {b, g, r};
  endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// One frame bank: simple dual-port RAM, one write port and one registered,
// enabled read port. The read register holds its value when re is low.
module frame_bank_ram
  import frame_buf_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_PIX_W,
  parameter int AW    = 14
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: zero-latency storage.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: one-cycle registered read, held between reads.
  always_ff @(posedge clk) begin
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/frame_pingpong_buf.sv
// Double-buffered pixel frame store. The writer fills wr_bank while scan-out
// reads rd_bank; banks change role only on a completing write (last address)
// or an rd_frame_done pulse, so scan-out never sees a partial frame.
module frame_pingpong_buf
  import frame_buf_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CH_W   = DEF_CH_W,
  parameter int NCH    = DEF_NCH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [NCH*CH_W-1:0]   wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [NCH*CH_W-1:0]   rd_data,
  output logic                  rd_valid,
  output logic                  frame_avail,
  input  logic                  rd_frame_done,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic                  err_ovf,
  output logic                  err_addr
);

  localparam int PIX_W  = NCH * CH_W;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  bank_state_t bank_st [2];

  logic             wr_in_rng, rd_in_rng;
  logic             wr_acc, wr_last, rd_acc, done_acc;
  logic             wr_oor, rd_oor;
  logic             we0, we1, re0, re1;
  logic [PIX_W-1:0] q0, q1;

  // Read-stage state: valid, which bank answered, and post-reset zeroing.
  logic             vld_p1;
  logic             rd_sel_p1;
  logic             rd_clr_p1;

  assign wr_ready    = (bank_st[wr_bank] == BANK_EMPTY);
  assign frame_avail = (bank_st[rd_bank] == BANK_FULL);

  assign wr_in_rng = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in_rng = ({1'b0, rd_addr} < DEPTH_X);

  assign wr_acc   = wr_en && wr_ready && wr_in_rng;
  assign wr_last  = wr_acc && (wr_addr == LAST_A);
  assign rd_acc   = rd_en && frame_avail && rd_in_rng;
  assign done_acc = rd_frame_done && frame_avail;

  assign wr_oor = wr_en && wr_ready && !wr_in_rng;
  assign rd_oor = rd_en && frame_avail && !rd_in_rng;

  assign we0 = wr_acc && !wr_bank;
  assign we1 = wr_acc &&  wr_bank;
  assign re0 = rd_acc && !rd_bank;
  assign re1 = rd_acc &&  rd_bank;

  frame_bank_ram #(.DEPTH(DEPTH), .WIDTH(PIX_W), .AW(RAM_AW)) u_bank0 (
    .clk   (clk),
    .we    (we0),
    .waddr (wr_addr[RAM_AW-1:0]),
    .wdata (wr_data),
    .re    (re0),
    .raddr (rd_addr[RAM_AW-1:0]),
    .q     (q0)
  );

  frame_bank_ram #(.DEPTH(DEPTH), .WIDTH(PIX_W), .AW(RAM_AW)) u_bank1 (
    .clk   (clk),
    .we    (we1),
    .waddr (wr_addr[RAM_AW-1:0]),
    .wdata (wr_data),
    .re    (re1),
    .raddr (rd_addr[RAM_AW-1:0]),
    .q     (q1)
  );

  // Bank roles: fill completion and frame-done always hit different banks
  // (one needs EMPTY, the other FULL), so both may act in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
    end else begin
      if (wr_last) begin
        bank_st[wr_bank] <= BANK_FULL;
        wr_bank          <= ~wr_bank;
      end
      if (done_acc) begin
        bank_st[rd_bank] <= BANK_EMPTY;
        rd_bank          <= ~rd_bank;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf  <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      err_ovf  <= err_ovf  | (wr_en && !wr_ready);
      err_addr <= err_addr | wr_oor | rd_oor;
    end
  end

  // Stage p0 -> p1: read accepted this cycle, data returns next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      rd_sel_p1 <= 1'b0;
      rd_clr_p1 <= 1'b1;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) begin
        rd_sel_p1 <= rd_bank;
        rd_clr_p1 <= 1'b0;
      end
    end
  end

  // The answering bank's read register holds between reads, so rd_data
  // keeps its last value; it reads as zero from reset until the first read.
  assign rd_valid = vld_p1;
  assign rd_data  = rd_clr_p1 ? '0 : (rd_sel_p1 ? q1 : q0);

endmodule

// File: doc/frame_pingpong_buf.md
# frame_pingpong_buf

Parametrised double-buffered (ping-pong) pixel frame store between the pixel fetch/write path and the display scan-out path. The writer fills one bank while the display reads the other. The two banks swap roles only under an explicit full/done handshake, so scan-out never reads a partially written frame. It supersedes the single-bank fixed 10000×24-bit buffer: depth, channel width and channel count are now parameters, and it adds flow control, read-valid and error reporting.

## Interface
Parameters:
- DEPTH, 10000: pixels per frame (words per bank).
- CH_W, 8: bits per colour channel.
- NCH, 3: channels per pixel. Channel 0 occupies the LSBs (R=[CH_W-1:0], then G, then B).
- ADDR_W, 20: address width. Must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  pixel index within the current write bank.
- wr_data  in  NCH*CH_W  packed pixel.
- wr_ready  out  1  current write bank is EMPTY/filling.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  pixel index within the current read bank.
- rd_data  out  NCH*CH_W  read pixel, registered.
- rd_valid  out  1  rd_data is valid this cycle.
- frame_avail  out  1  current read bank is FULL.
- rd_frame_done  in  1  one-cycle pulse: scan-out of the read bank is finished.
- wr_bank, rd_bank  out  1 each  current bank indices.
- err_ovf  out  1  sticky: write rejected (wr_en while !wr_ready).
- err_addr  out  1  sticky: wr_addr or rd_addr ≥ DEPTH on an accepted request.

## Operation
- Each bank has a 1-bit state, EMPTY or FULL. Two pointers track roles: wr_bank and rd_bank.
- Write acceptance:
  - A write is accepted when wr_en && wr_ready && wr_addr < DEPTH.
  - Accepted data is stored at bank[wr_bank][wr_addr].
  - If wr_en && !wr_ready, nothing is stored and err_ovf sets.
  - If wr_addr ≥ DEPTH, nothing is stored and err_addr sets.
- Fill completion: an accepted write to wr_addr == DEPTH-1 sets bank[wr_bank] to FULL and toggles wr_bank. Earlier addresses may arrive in any order and are not checked for coverage.
- Read acceptance:
  - A read is accepted when rd_en && frame_avail && rd_addr < DEPTH.
  - On the next cycle rd_data = bank[rd_bank][rd_addr] and rd_valid = 1.
  - If rd_en arrives without frame_avail, rd_valid stays 0 and rd_data holds its last value.
  - A read with rd_addr ≥ DEPTH sets err_addr and gives no rd_valid.
- Frame done:
  - rd_frame_done while frame_avail sets bank[rd_bank] to EMPTY and toggles rd_bank.
  - rd_frame_done while !frame_avail is ignored.
- Simultaneous events:
  - Write completion and rd_frame_done on different banks in the same cycle both take effect.
  - rd_en and rd_frame_done in the same cycle: the read is served from the old bank and its data is returned next cycle, then the swap happens.
- Reset:
  - Both banks go EMPTY; wr_bank = rd_bank = 0.
  - rd_data = 0, rd_valid = 0, err_ovf = err_addr = 0.
  - Derived outputs after reset: wr_ready = 1, frame_avail = 0.
  - RAM contents are not cleared.
  - Reset asserted mid-frame discards the partial frame; any in-flight rd_valid drops immediately.

## Timing
- Read latency is 1 cycle, from rd_en sampled to rd_valid/rd_data.
- Write is 0-latency storage; data is readable only after the bank becomes FULL and is swapped in.
- wr_ready and frame_avail are combinational from the registered bank state and pointers. They update the cycle after the completing write or the done pulse.
- Fastest write-to-scan-out: the last write at cycle N gives frame_avail = 1 at N+1 (if rd_bank already points at that bank).
- With both banks FULL, wr_ready = 0 until rd_frame_done. The writer stalls; no data is lost.
- Error flags are sticky until reset.

## Structure
- Shared package frame_buf_pkg:
  - typedef bank_state_t {BANK_EMPTY, BANK_FULL}.
  - Default DEPTH/CH_W/NCH constants.
  - Function pix_pack(r,g,b) for packing pixels.
- Sub-module frame_bank_ram: a simple dual-port RAM (one write port, one registered read port), DEPTH × NCH*CH_W. It is instantiated twice.
- The top level holds the pointers, bank-state registers, error flags and the read-valid pipeline.

## Test plan
All scenarios use DEPTH=4, CH_W=8, NCH=3.
- Reset: drive reset mid-stream → all outputs go to their reset values immediately; wr_ready = 1, frame_avail = 0, wr_bank = rd_bank = 0.
- Single frame: write 0x0000FF, 0x00FF00, 0xFF0000, 0x123456 to addresses 0..3 → frame_avail = 1 next cycle and wr_bank = 1. rd_en at addr 2 → one cycle later rd_valid = 1, rd_data = 0xFF0000.
- Backpressure: fill both banks without any rd_frame_done → wr_ready = 0. A further wr_en sets err_ovf and changes no RAM content. rd_frame_done → wr_ready = 1, rd_bank = 1.
- Overlap: the completing write of bank 1 and rd_frame_done on bank 0 in the same cycle → next cycle bank 0 = EMPTY, bank 1 = FULL, rd_bank = 1, frame_avail = 1.
- Read/done collision: rd_en (addr 3) together with rd_frame_done → rd_data = 0x123456 from the old bank next cycle, and rd_bank toggles.
- Address error: wr_addr = 4 → err_addr = 1, no storage, and the bank does not become FULL.
